// File: rtl/rf_wb_writer_pkg.sv
// Shared widths and queue-entry type for the register-file write-back writer.
// Latency: n/a. Backpressure: n/a.
package rf_wb_writer_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } q_entry_t;
endpackage

// File: rtl/rfwb_queue.sv
// In-order circular buffer of mul/div results with kill-by-rd and a busy vector.
// Latency: push visible at head next cycle. Backpressure: caller must not push when full.
module rfwb_queue
    import rf_wb_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [REG_W-1:0]  push_rd,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill_vld,
    input  logic [REG_W-1:0]  kill_rd,
    output q_entry_t          head,
    output logic              full,
    output logic              empty,
    output logic [31:0]       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    q_entry_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_vld && mem[i].rd == kill_rd) mem[i].live <= 1'b0;
            end
            // Popped slots drop live so busy only ever sees occupied entries.
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (push) begin
                mem[wr_ptr] <= '{live: 1'b1, rd: push_rd, data: push_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].live) busy[mem[i].rd] = 1'b1;
        end
        busy[0] = 1'b0;
    end
endmodule

// File: rtl/rf_wb_writer.sv
// Merges WB writes (priority) and queued mul/div results onto the register-file write port.
// Latency: 1 cycle to rf_* outputs. Backpressure: md_ready = !full; WB is never stalled.
// Optional RFWB_BYPASS_EN adds combinational read bypass from the registered write port.
module rf_wb_writer
    import rf_wb_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy
`ifdef RFWB_BYPASS_EN
    ,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [31:0] byp_data1,
    output logic [31:0] byp_data2
`endif
);
    logic     wb_we;
    logic     push;
    logic     pop;
    logic     q_full;
    logic     q_empty;
    q_entry_t head;

    assign wb_we    = wb_valid && (wb_rd != REG_ZERO);
    assign md_ready = !q_full;
    // An md result already overwritten by a same-cycle WB write is dropped.
    assign push     = md_valid && md_ready && (md_rd != REG_ZERO)
                      && !(wb_we && (md_rd == wb_rd));
    assign pop      = !wb_we && !q_empty;

    rfwb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_rd   (md_rd),
        .push_data (md_data),
        .pop       (pop),
        .kill_vld  (wb_we),
        .kill_rd   (wb_rd),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .busy      (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (wb_we) begin
            rf_we    <= 1'b1;
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
        end else if (pop && head.live) begin
            rf_we    <= 1'b1;
            rf_waddr <= head.rd;
            rf_wdata <= head.data;
        end else begin
            // Killed-head pops and idle cycles both waste the slot.
            rf_we    <= 1'b0;
        end
    end

`ifdef RFWB_BYPASS_EN
    assign byp_hit1  = rf_we && (rf_waddr == rd_a1) && (rd_a1 != REG_ZERO);
    assign byp_hit2  = rf_we && (rf_waddr == rd_a2) && (rd_a2 != REG_ZERO);
    assign byp_data1 = byp_hit1 ? rf_wdata : '0;
    assign byp_data2 = byp_hit2 ? rf_wdata : '0;
`endif
endmodule

// File: tb/tb_rf_wb_writer.sv
// Directed vector bench for rf_wb_writer (DEPTH=4).
module tb_rf_wb_writer;
    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
`ifdef RFWB_BYPASS_EN
    logic [4:0]  rd_a1, rd_a2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;
`endif

    int n_vec = 0;
    int n_bad = 0;

    rf_wb_writer #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .md_valid (md_valid),
        .md_rd    (md_rd),
        .md_data  (md_data),
        .md_ready (md_ready),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .busy     (busy)
`ifdef RFWB_BYPASS_EN
        ,
        .rd_a1    (rd_a1),
        .rd_a2    (rd_a2),
        .byp_hit1 (byp_hit1),
        .byp_hit2 (byp_hit2),
        .byp_data1(byp_data1),
        .byp_data2(byp_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [31:0] ebusy;
        logic        erdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                       input logic [31:0] ebusy, input logic erdy);
        vec_t v;
        v = '{wv, wr, wd, mv, mr, md, ewe, ewa, ewd, ebusy, erdy};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        md_valid = mv; md_rd = mr; md_data = md;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
`ifdef RFWB_BYPASS_EN
        rd_a1 = 0; rd_a2 = 0;
`endif
        // Outputs seen by each vector are the ones after the edge that consumed its inputs.
        //   wv wr  wd            mv mr  md          ewe ewa ewd           ebusy         erdy
        add(0, 0,  32'h0,         0, 0,  32'h0,      0,  0,  32'h0,        32'h0,        1); // idle
        add(1, 5,  32'hDEADBEEF,  0, 0,  32'h0,      1,  5,  32'hDEADBEEF, 32'h0,        1); // WB r5
        add(1, 0,  32'h1234,      0, 0,  32'h0,      0,  5,  32'hDEADBEEF, 32'h0,        1); // WB r0 no write
        add(1, 1,  32'h11,        1, 8,  32'h12,     1,  1,  32'h11,       32'h100,      1); // md r8 under WB
        add(1, 2,  32'h22,        0, 0,  32'h0,      1,  2,  32'h22,       32'h100,      1);
        add(1, 3,  32'h33,        0, 0,  32'h0,      1,  3,  32'h33,       32'h100,      1);
        add(0, 0,  32'h0,         0, 0,  32'h0,      1,  8,  32'h12,       32'h0,        1); // r8 drains
        add(0, 0,  32'h0,         0, 0,  32'h0,      0,  8,  32'h12,       32'h0,        1);
        add(0, 0,  32'h0,         1, 9,  32'h99,     0,  8,  32'h12,       32'h200,      1); // md r9
        add(1, 9,  32'h77,        0, 0,  32'h0,      1,  9,  32'h77,       32'h0,        1); // WB kills r9
        add(0, 0,  32'h0,         0, 0,  32'h0,      0,  9,  32'h77,       32'h0,        1); // killed pop
        add(0, 0,  32'h0,         0, 0,  32'h0,      0,  9,  32'h77,       32'h0,        1);
        add(1, 1,  32'hA1,        1, 10, 32'hB0,     1,  1,  32'hA1,       32'h400,      1); // fill
        add(1, 2,  32'hA2,        1, 11, 32'hB1,     1,  2,  32'hA2,       32'hC00,      1);
        add(1, 3,  32'hA3,        1, 12, 32'hB2,     1,  3,  32'hA3,       32'h1C00,     1);
        add(1, 4,  32'hA4,        1, 13, 32'hB3,     1,  4,  32'hA4,       32'h3C00,     0); // full
        add(1, 5,  32'hA5,        1, 14, 32'hB4,     1,  5,  32'hA5,       32'h3C00,     0); // refused
        add(0, 0,  32'h0,         1, 14, 32'hB4,     1,  10, 32'hB0,       32'h3800,     1); // pop, still refused
        add(0, 0,  32'h0,         1, 14, 32'hB4,     1,  11, 32'hB1,       32'h7000,     1); // push+pop
        add(0, 0,  32'h0,         0, 0,  32'h0,      1,  12, 32'hB2,       32'h6000,     1);
        add(0, 0,  32'h0,         0, 0,  32'h0,      1,  13, 32'hB3,       32'h4000,     1);
        add(0, 0,  32'h0,         0, 0,  32'h0,      1,  14, 32'hB4,       32'h0,        1);
        add(0, 0,  32'h0,         0, 0,  32'h0,      0,  14, 32'hB4,       32'h0,        1);
        add(0, 0,  32'h0,         1, 0,  32'h55,     0,  14, 32'hB4,       32'h0,        1); // md r0 dropped
        add(0, 0,  32'h0,         0, 0,  32'h0,      0,  14, 32'hB4,       32'h0,        1);
        add(1, 6,  32'h66,        1, 6,  32'hEE,     1,  6,  32'h66,       32'h0,        1); // same-rd md dropped
        add(0, 0,  32'h0,         0, 0,  32'h0,      0,  6,  32'h66,       32'h0,        1);

        #2;
        chk("rst_we",    {31'h0, rf_we},    32'h0);
        chk("rst_waddr", {27'h0, rf_waddr}, 32'h0);
        chk("rst_wdata", rf_wdata,          32'h0);
        chk("rst_busy",  busy,              32'h0);
        chk("rst_ready", {31'h0, md_ready}, 32'h1);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wv, vecs[i].wr, vecs[i].wd, vecs[i].mv, vecs[i].mr, vecs[i].md);
            step();
            chk($sformatf("v%0d_we", i),    {31'h0, rf_we},    {31'h0, vecs[i].ewe});
            if (vecs[i].ewe || i > 0) begin
                chk($sformatf("v%0d_waddr", i), {27'h0, rf_waddr}, {27'h0, vecs[i].ewa});
                chk($sformatf("v%0d_wdata", i), rf_wdata,          vecs[i].ewd);
            end
            chk($sformatf("v%0d_busy", i),  busy,              vecs[i].ebusy);
            chk($sformatf("v%0d_ready", i), {31'h0, md_ready}, {31'h0, vecs[i].erdy});
        end

`ifdef RFWB_BYPASS_EN
        drive(1, 3, 32'h3333, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        rd_a1 = 3; rd_a2 = 0;
        #1;
        chk("byp_hit1",  {31'h0, byp_hit1}, 32'h1);
        chk("byp_data1", byp_data1,         32'h3333);
        chk("byp_hit2",  {31'h0, byp_hit2}, 32'h0);
        rd_a1 = 0;
        #1;
        chk("byp_hit1_r0", {31'h0, byp_hit1}, 32'h0);
        chk("byp_data1_r0", byp_data1,        32'h0);
        step();
`endif

        // Two md results parked behind WB traffic, then reset mid-cycle.
        drive(1, 1, 32'h1, 1, 20, 32'hC0);
        step();
        drive(1, 2, 32'h2, 1, 21, 32'hC1);
        step();
        chk("pre_rst_busy", busy, 32'h0030_0000);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  busy,              32'h0);
        chk("mid_rst_we",    {31'h0, rf_we},    32'h0);
        chk("mid_rst_waddr", {27'h0, rf_waddr}, 32'h0);
        chk("mid_rst_ready", {31'h0, md_ready}, 32'h1);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst%0d_we", k),   {31'h0, rf_we}, 32'h0);
            chk($sformatf("post_rst%0d_busy", k), busy,           32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_wb_writer.md
# rf_wb_writer

Write-back side driver for the pipeline's 32x32 register file write port. Merges the single-cycle pipeline write-back stream with results from the multicycle multiply/divide unit onto the one register-file write port. Pending long-latency results are buffered in a small in-order queue, and a per-register busy scoreboard is exported to the hazard unit. Sits between the WB stage / mul-div unit and the register file's write inputs (A3, WD, RFWr).

## Interface
- DEPTH, 4, queue entries for mul/div results; power of two, 2..16
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  pipeline WB stage has a register write this cycle; cannot be stalled
- wb_rd  in  5  destination register of WB write
- wb_data  in  32  WB write data
- md_valid  in  1  mul/div result offered
- md_rd  in  5  mul/div destination register
- md_data  in  32  mul/div result
- md_ready  out  1  queue can accept; equals !full (registered count)
- rf_we  out  1  drives register file RFWr
- rf_waddr  out  5  drives register file A3
- rf_wdata  out  32  drives register file WD
- busy  out  32  bit r set while a live queued write to r exists; bit 0 always 0
- rd_a1, rd_a2  in  5  read addresses (only with RFWB_BYPASS_EN)
- byp_hit1, byp_hit2  out  1  bypass hit (only with RFWB_BYPASS_EN)
- byp_data1, byp_data2  out  32  bypass data (only with RFWB_BYPASS_EN)

## Operation
- Write-port outputs are registered. Each cycle selects at most one source for the next cycle's write:
  - WB has absolute priority: if wb_valid && wb_rd!=0, the next cycle presents wb_rd/wb_data with rf_we=1.
  - Otherwise, if the queue head is live, the head is popped and presented.
  - Otherwise, if the queue head is killed, it is popped with rf_we=0 for the next cycle. The write slot is wasted; this is accepted.
  - Otherwise rf_we=0. rf_waddr/rf_wdata hold their last values.
- Writes to r0 are never issued. A WB write with wb_rd==0 counts as no write. An md transfer with md_rd==0 is accepted and discarded without being enqueued.
- Enqueue happens on md_valid && md_ready. The entry holds {live, rd, data}.
- WAW kill: an accepted WB write to rd X clears live on every queued entry with rd==X. An md transfer accepted in the same cycle with md_rd==X is discarded rather than enqueued.
- Enqueue and pop may occur in the same cycle. The count is unchanged in that case.
- busy[r] is the OR over live entries of the decoded rd. It is registered and reflects queue state after the last clock edge.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - queue empty, busy=0
  - md_ready=1 (queue empty, so !full is true during and after reset)
- Reset mid-operation discards all queued entries. No write is issued for them.
- WB latency: input at edge t appears on rf_* during cycle t+1. The register file commits it at edge t+2.
- MD latency, best case: accepted at edge t, popped at edge t+1 if wb_valid is low, presented during t+2.
- Under continuous wb_valid, the queue never drains. md_ready falls once count==DEPTH.
- Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).

## Configuration
- RFWB_BYPASS_EN defined: adds rd_a1/rd_a2 and the byp_* ports.
  - byp_hitN = rf_we && rf_waddr==rd_aN && rd_aN!=0.
  - byp_dataN = rf_wdata when hit, else 0.
  - Purely combinational from the registered write port. Covers a read in the same cycle as the write presentation.
- Not defined: those ports and that logic are absent. All other behaviour is identical.

## Structure
- The shared package holds:
  - REG_W=5 and DATA_W=32
  - the queue-entry typedef {live, rd, data}
  - the REG_ZERO constant
- One sub-module, rfwb_queue: DEPTH-entry circular buffer with kill-by-rd and busy-vector generation.
- The top-level handles arbitration, the write-port registers and the optional bypass.

## Test plan
- Reset, then idle → rf_we=0, busy=0, md_ready=1. Assert rst_n low mid-queue (count=2) → queue empties immediately and busy=0.
- WB writes r5=0xDEADBEEF at edge t → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle t+1; wb_rd=0 → rf_we stays 0.
- md r8=0x12 enqueued while wb_valid is held high for 3 cycles → busy[8]=1 throughout; r8 is written the first cycle after wb_valid drops, then busy[8]=0.
- Enqueue md r9, then WB writes r9=0x77 before drain → busy[9] clears, no later write to r9 with the md value; a killed-pop cycle shows rf_we=0.
- Fill with DEPTH=4 md results under a continuous WB stream → md_ready=0 after the 4th accept; same-cycle md_valid with a pop frees a slot only on the next cycle.
- With RFWB_BYPASS_EN: rf_we=1, rf_waddr=3, rd_a1=3 → byp_hit1=1 with byp_data1=rf_wdata; rd_a1=0 → byp_hit1=0.
